// File: rtl/gin_pkg.sv
// Shared definitions for the GIN multicast source: default widths,
// FSM state encoding and the packet layout.
package gin_pkg;

  localparam int GIN_ID_LEN    = 4;
  localparam int GIN_VALUE_LEN = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CFG   = 2'd1,
    FLUSH = 2'd2,
    RUN   = 2'd3
  } gin_state_e;

  typedef struct packed {
    logic [GIN_ID_LEN-1:0]    tag;
    logic [GIN_VALUE_LEN-1:0] value;
  } gin_pkt_t;

endpackage

// File: rtl/gin_multicast_source_if.sv
// Bundle of the config scan-chain, packet-input and GIN-bus signals.
// master: the multicast source; slave: the environment around it.
interface gin_multicast_source_if
  import gin_pkg::*;
#(
  parameter int ID_LEN    = GIN_ID_LEN,
  parameter int VALUE_LEN = GIN_VALUE_LEN
) ();

  logic                 cfg_start;
  logic                 cfg_valid;
  logic [ID_LEN-1:0]    cfg_id;
  logic                 cfg_ready;
  logic                 cfg_done;
  logic                 set_id;
  logic [ID_LEN-1:0]    id_out;
  logic                 pkt_valid;
  logic [ID_LEN-1:0]    pkt_tag;
  logic [VALUE_LEN-1:0] pkt_value;
  logic                 pkt_ready;
  logic                 gin_enable;
  logic [ID_LEN-1:0]    gin_tag;
  logic [VALUE_LEN-1:0] gin_value;
  logic                 gin_ready;

  modport master (
    input  cfg_start, cfg_valid, cfg_id, pkt_valid, pkt_tag, pkt_value, gin_ready,
    output cfg_ready, cfg_done, set_id, id_out, pkt_ready, gin_enable, gin_tag, gin_value
  );

  modport slave (
    output cfg_start, cfg_valid, cfg_id, pkt_valid, pkt_tag, pkt_value, gin_ready,
    input  cfg_ready, cfg_done, set_id, id_out, pkt_ready, gin_enable, gin_tag, gin_value
  );

endinterface

// File: rtl/gin_sync_fifo.sv
// Synchronous FIFO with full/empty flags. The head entry is read straight
// from the storage registers, so it is valid in the cycle after a push.
module gin_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit to tell full from empty.
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_do_push;
  logic             w_do_pop;

  assign w_do_push = i_push & ~o_full;
  assign w_do_pop  = i_pop & ~o_empty;
  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_head    = r_mem[r_rd_ptr[AW-1:0]];

  // Advance read/write pointers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

  // Write the storage array.
  // NOTE: storage is deliberately not reset; the pointers alone define
  // which entries are valid, and an unreset array maps to plain flops/RAM.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/gin_multicast_source.sv
// Transmit end of the GIN multicast protocol: programs controller IDs over
// the set_id/id scan chain, then issues buffered packets on the GIN bus.
module gin_multicast_source
  import gin_pkg::*;
#(
  parameter int ID_LEN     = GIN_ID_LEN,
  parameter int VALUE_LEN  = GIN_VALUE_LEN,
  parameter int NUM_NODES  = 12,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  gin_multicast_source_if.master  bus,
  output logic                    busy,
  output logic [CNT_W-1:0]        issued_count
);

  localparam int NW = $clog2(NUM_NODES + 1);
  localparam int PW = ID_LEN + VALUE_LEN;

  gin_state_e        r_state;
  gin_state_e        w_next_state;
  logic [NW-1:0]     r_node_cnt;
  logic              r_set_id;
  logic [ID_LEN-1:0] r_id_out;
  logic              r_cfg_done;
  logic [CNT_W-1:0]  r_issued_cnt;

  logic              w_cfg_ready;
  logic              w_cfg_accept;
  logic              w_last_word;
  logic              w_gin_enable;
  logic              w_transfer;
  logic              w_push;
  logic              w_fifo_full;
  logic              w_fifo_empty;
  logic [PW-1:0]     w_head;

  assign w_cfg_accept = bus.cfg_valid & w_cfg_ready;
  assign w_last_word  = w_cfg_accept && (r_node_cnt == NW'(NUM_NODES - 1));
  assign w_transfer   = w_gin_enable & bus.gin_ready;
  assign w_push       = bus.pkt_valid & ~w_fifo_full;

  gin_sync_fifo #(
    .WIDTH (PW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  ({bus.pkt_tag, bus.pkt_value}),
    .i_pop   (w_transfer),
    .o_head  (w_head),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  // State register.
  // NOTE: all sequential state uses non-blocking assignment so every flop
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  // Next-state logic; cfg_start is only honoured outside configuration.
  // NOTE: the default assignment up front keeps this purely combinational.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (bus.cfg_start) w_next_state = CFG;
      CFG:     if (w_last_word)   w_next_state = FLUSH;
      FLUSH:                      w_next_state = RUN;
      RUN:     if (bus.cfg_start) w_next_state = CFG;
      default:                    w_next_state = IDLE;
    endcase
  end

  // State-decoded outputs: ID acceptance, bus enable and busy flag.
  always_comb begin
    w_cfg_ready  = (r_state == CFG);
    w_gin_enable = (r_state == RUN) && !w_fifo_empty;
    busy         = (r_state != RUN) || !w_fifo_empty;
  end

  // Count programmed nodes; restart whenever a new configuration begins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_node_cnt <= '0;
    end else if ((r_state == IDLE || r_state == RUN) && bus.cfg_start) begin
      r_node_cnt <= '0;
    end else if (w_cfg_accept) begin
      r_node_cnt <= r_node_cnt + NW'(1);
    end
  end

  // Registered scan-chain drive and the configuration-done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_set_id   <= 1'b0;
      r_id_out   <= '0;
      r_cfg_done <= 1'b0;
    end else begin
      r_set_id   <= w_cfg_accept;
      if (w_cfg_accept) r_id_out <= bus.cfg_id;
      r_cfg_done <= (r_state == FLUSH);
    end
  end

  // Count completed bus transfers, wrapping naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)             r_issued_cnt <= '0;
    else if (w_transfer) r_issued_cnt <= r_issued_cnt + CNT_W'(1);
  end

  assign bus.cfg_ready  = w_cfg_ready;
  assign bus.cfg_done   = r_cfg_done;
  assign bus.set_id     = r_set_id;
  assign bus.id_out     = r_id_out;
  assign bus.pkt_ready  = ~w_fifo_full;
  assign bus.gin_enable = w_gin_enable;
  assign bus.gin_tag    = w_gin_enable ? w_head[PW-1 -: ID_LEN] : '0;
  assign bus.gin_value  = w_gin_enable ? w_head[VALUE_LEN-1:0] : '0;
  assign issued_count   = r_issued_cnt;

endmodule

// File: tb/tb_gin_multicast_source.sv
// Self-checking bench for gin_multicast_source: scoreboard of accepted
// packets compared against bus transfers, plus a 3-node scan-chain model.
module tb_gin_multicast_source;
  import gin_pkg::*;

  localparam int NODES = 3;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             busy;
  logic [CNT_W-1:0] issued_count;

  gin_multicast_source_if #(.ID_LEN(GIN_ID_LEN), .VALUE_LEN(GIN_VALUE_LEN)) bus ();

  gin_multicast_source #(
    .ID_LEN     (GIN_ID_LEN),
    .VALUE_LEN  (GIN_VALUE_LEN),
    .NUM_NODES  (NODES),
    .FIFO_DEPTH (4),
    .CNT_W      (CNT_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .busy         (busy),
    .issued_count (issued_count)
  );

  always #5 clk = ~clk;

  int               n_checks = 0;
  int               n_fail   = 0;
  gin_pkt_t         sb[$];
  gin_pkt_t         exp_pkt;
  logic [CNT_W-1:0] model_cnt = '0;
  int               setid_cnt = 0;
  int               done_cnt  = 0;
  logic [3:0]       chain [NODES];
  logic             hold_pend = 1'b0;
  logic [35:0]      hold_val  = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Monitor at the falling edge: chain model, scoreboard and hold checks.
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      model_cnt = '0;
      hold_pend = 1'b0;
      for (int i = 0; i < NODES; i++) chain[i] = '0;
    end else begin
      if (bus.set_id) begin
        setid_cnt++;
        for (int i = NODES - 1; i > 0; i--) chain[i] = chain[i-1];
        chain[0] = bus.id_out;
      end
      if (bus.cfg_done) done_cnt++;
      if (hold_pend) begin
        check("hold_enable", 64'(bus.gin_enable), 64'd1);
        check("hold_data", 64'({bus.gin_tag, bus.gin_value}), 64'(hold_val));
      end
      if (bus.gin_enable && bus.gin_ready) begin
        check("issue_expected", 64'(sb.size() > 0), 64'd1);
        if (sb.size() > 0) begin
          exp_pkt = sb.pop_front();
          check("issue_tag", 64'(bus.gin_tag), 64'(exp_pkt.tag));
          check("issue_value", 64'(bus.gin_value), 64'(exp_pkt.value));
        end
        check("issue_count", 64'(issued_count), 64'(model_cnt));
        model_cnt = model_cnt + CNT_W'(1);
      end
      hold_pend = bus.gin_enable && !bus.gin_ready && !bus.cfg_start;
      hold_val  = {bus.gin_tag, bus.gin_value};
      if (bus.pkt_valid && bus.pkt_ready) sb.push_back({bus.pkt_tag, bus.pkt_value});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_pkt(input logic [3:0] tag, input logic [31:0] value);
    bus.pkt_valid = 1'b1;
    bus.pkt_tag   = tag;
    bus.pkt_value = value;
    tick();
    bus.pkt_valid = 1'b0;
  endtask

  // Program the chain with IDs NODES-1 .. 0 and check the full handshake.
  task automatic do_config(input string tag, input logic rdy);
    int s0;
    int d0;
    s0 = setid_cnt;
    d0 = done_cnt;
    bus.cfg_start = 1'b1;
    tick();
    bus.cfg_start = 1'b0;
    bus.gin_ready = rdy;
    check({tag, "_cfg_ready"}, 64'(bus.cfg_ready), 64'd1);
    for (int i = NODES - 1; i >= 0; i--) begin
      check({tag, "_cfg_enable"}, 64'(bus.gin_enable), 64'd0);
      bus.cfg_valid = 1'b1;
      bus.cfg_id    = 4'(i);
      tick();
    end
    bus.cfg_valid = 1'b0;
    check({tag, "_flush_ready"}, 64'(bus.cfg_ready), 64'd0);
    check({tag, "_flush_set_id"}, 64'(bus.set_id), 64'd1);
    check({tag, "_flush_id_out"}, 64'(bus.id_out), 64'd0);
    check({tag, "_flush_done"}, 64'(bus.cfg_done), 64'd0);
    check({tag, "_flush_enable"}, 64'(bus.gin_enable), 64'd0);
    tick();
    check({tag, "_done"}, 64'(bus.cfg_done), 64'd1);
    check({tag, "_set_id_low"}, 64'(bus.set_id), 64'd0);
    tick();
    check({tag, "_done_once"}, 64'(bus.cfg_done), 64'd0);
    check({tag, "_set_id_pulses"}, 64'(setid_cnt - s0), 64'd3);
    check({tag, "_done_pulses"}, 64'(done_cnt - d0), 64'd1);
    for (int i = 0; i < NODES; i++) check({tag, "_chain"}, 64'(chain[i]), 64'(i));
  endtask

  task automatic wait_drain(input string tag, input int max_cycles);
    for (int i = 0; i < max_cycles && sb.size() != 0; i++) tick();
    check({tag, "_drain"}, 64'(sb.size()), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst           = 1'b1;
    bus.cfg_start = 1'b0;
    bus.cfg_valid = 1'b0;
    bus.cfg_id    = '0;
    bus.pkt_valid = 1'b0;
    bus.pkt_tag   = '0;
    bus.pkt_value = '0;
    bus.gin_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_set_id", 64'(bus.set_id), 64'd0);
    check("rst_id_out", 64'(bus.id_out), 64'd0);
    check("rst_cfg_ready", 64'(bus.cfg_ready), 64'd0);
    check("rst_cfg_done", 64'(bus.cfg_done), 64'd0);
    check("rst_enable", 64'(bus.gin_enable), 64'd0);
    check("rst_tag", 64'(bus.gin_tag), 64'd0);
    check("rst_value", 64'(bus.gin_value), 64'd0);
    check("rst_issued", 64'(issued_count), 64'd0);
    check("rst_pkt_ready", 64'(bus.pkt_ready), 64'd1);
    check("rst_busy", 64'(busy), 64'd1);
    rst = 1'b0;
    tick();

    // 1: configuration of a 3-node chain.
    do_config("cfg1", 1'b0);
    check("run_busy", 64'(busy), 64'd0);

    // 2: single packet issue.
    bus.gin_ready = 1'b1;
    push_pkt(4'd1, 32'hDEADBEEF);
    check("basic_enable", 64'(bus.gin_enable), 64'd1);
    check("basic_tag", 64'(bus.gin_tag), 64'd1);
    check("basic_value", 64'(bus.gin_value), 64'hDEADBEEF);
    tick();
    check("basic_enable_off", 64'(bus.gin_enable), 64'd0);
    check("basic_issued", 64'(issued_count), 64'd1);

    // 3: backpressure, then a back-to-back drain.
    bus.gin_ready = 1'b0;
    for (int v = 10; v <= 13; v++) push_pkt(4'(v - 8), 32'(v));
    check("bp_pkt_ready", 64'(bus.pkt_ready), 64'd0);
    check("bp_head", 64'(bus.gin_value), 64'd10);
    repeat (5) tick();
    check("bp_head_held", 64'(bus.gin_value), 64'd10);
    bus.gin_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("bp_drain_enable", 64'(bus.gin_enable), 64'd1);
      check("bp_drain_value", 64'(bus.gin_value), 64'(10 + i));
      tick();
    end
    check("bp_empty", 64'(bus.gin_enable), 64'd0);
    check("bp_issued", 64'(issued_count), 64'd5);

    // 4: full FIFO with a simultaneous pop and offered push.
    bus.gin_ready = 1'b0;
    for (int v = 20; v <= 23; v++) push_pkt(4'd2, 32'(v));
    check("full_pkt_ready", 64'(bus.pkt_ready), 64'd0);
    bus.gin_ready = 1'b1;
    bus.pkt_valid = 1'b1;
    bus.pkt_tag   = 4'd5;
    bus.pkt_value = 32'd24;
    check("full_refuse", 64'(bus.pkt_ready), 64'd0);
    tick();
    check("full_reopen", 64'(bus.pkt_ready), 64'd1);
    check("full_head", 64'(bus.gin_value), 64'd21);
    tick();
    bus.pkt_valid = 1'b0;
    check("full_issued_step", 64'(issued_count), 64'd7);
    wait_drain("full", 10);
    check("full_issued", 64'(issued_count), 64'd10);

    // 5: reconfiguration with packets queued.
    bus.gin_ready = 1'b0;
    push_pkt(4'd1, 32'd30);
    push_pkt(4'd2, 32'd31);
    check("recfg_enable_pre", 64'(bus.gin_enable), 64'd1);
    do_config("cfg2", 1'b1);
    wait_drain("recfg", 10);
    check("recfg_issued", 64'(issued_count), 64'd12);

    // 6: asynchronous reset in the middle of configuration.
    bus.gin_ready = 1'b0;
    push_pkt(4'd3, 32'd40);
    bus.cfg_start = 1'b1;
    tick();
    bus.cfg_start = 1'b0;
    bus.cfg_valid = 1'b1;
    bus.cfg_id    = 4'd2;
    tick();
    bus.cfg_valid = 1'b0;
    check("midcfg_set_id", 64'(bus.set_id), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    check("arst_set_id", 64'(bus.set_id), 64'd0);
    check("arst_cfg_ready", 64'(bus.cfg_ready), 64'd0);
    check("arst_pkt_ready", 64'(bus.pkt_ready), 64'd1);
    check("arst_issued", 64'(issued_count), 64'd0);
    check("arst_busy", 64'(busy), 64'd1);
    check("arst_enable", 64'(bus.gin_enable), 64'd0);
    tick();
    rst = 1'b0;
    tick();
    do_config("cfg3", 1'b1);
    check("post_rst_enable", 64'(bus.gin_enable), 64'd0);
    check("post_rst_busy", 64'(busy), 64'd0);
    check("post_rst_issued", 64'(issued_count), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/gin_multicast_source.md
Name: gin_multicast_source

Overview:
- Transmit end of the GIN multicast protocol. It feeds the tag/value/enable bus that a row or column of GIN multicast controllers decodes, and it is released by the aggregated ready returned from that bus.
- Programs the endpoint IDs through the controllers' set_id/id scan chain. It then buffers tagged packets from the global buffer and issues them with a valid/ready handshake.
- Sits between the global-buffer read port and the GIN row/column bus, one instance per bus.

Parameters:
- ID_LEN, 4, width of tags and endpoint IDs.
- VALUE_LEN, 32, payload width.
- NUM_NODES, 12, number of controllers on the scan chain.
- FIFO_DEPTH, 4, packet buffer entries; power of two, ≥2.
- CNT_W, 16, width of the issued-packet counter.

Ports:
- clk, input, 1, clock.
- rst, input, 1, reset, asynchronous, active-high.
- cfg_start, input, 1, one-cycle request to (re)program the scan chain.
- cfg_valid, input, 1, a cfg_id word is offered.
- cfg_id, input, ID_LEN, ID to shift in; last node's ID first.
- cfg_ready, output, 1, ID word accepted when cfg_valid & cfg_ready.
- cfg_done, output, 1, one-cycle pulse when the chain is programmed.
- set_id, output, 1, scan-chain shift enable to all controllers.
- id_out, output, ID_LEN, scan-chain data into the first controller's id_in.
- pkt_valid, input, 1, a packet is offered.
- pkt_tag, input, ID_LEN, destination tag.
- pkt_value, input, VALUE_LEN, payload.
- pkt_ready, output, 1, packet accepted when pkt_valid & pkt_ready.
- gin_enable, output, 1, bus enable to the controllers' enable_in.
- gin_tag, output, ID_LEN, bus tag.
- gin_value, output, VALUE_LEN, bus value.
- gin_ready, input, 1, aggregated ready_out from the bus.
- busy, output, 1, asserted when state != RUN or the FIFO is non-empty.
- issued_count, output, CNT_W, number of completed transfers.

Behaviour:
- Reset values:
  - state = IDLE.
  - set_id, id_out, cfg_ready, cfg_done, gin_enable, gin_tag, gin_value and issued_count all 0.
  - pkt_ready = 1 (FIFO empty); busy = 1.
  - FIFO pointers cleared.
- FSM states are IDLE, CFG, FLUSH and RUN.
- IDLE:
  - cfg_ready = 0.
  - cfg_start → CFG, and the node counter is cleared.
- CFG:
  - cfg_ready = 1.
  - Each accepted word increments the node counter and registers set_id = 1 and id_out = cfg_id for the next cycle.
  - set_id = 0 on any cycle following a non-accept cycle; id_out holds its last value.
  - The accept that brings the count to NUM_NODES → FLUSH.
  - cfg_start is ignored while in CFG.
- FLUSH:
  - Exactly 1 cycle, carrying the final set_id pulse.
  - cfg_ready = 0.
  - → RUN with cfg_done = 1 in the first RUN cycle.
  - No issue happens before the controllers have latched their IDs.
- RUN:
  - gin_enable = (FIFO non-empty), taken combinationally from the registered FIFO head.
  - gin_tag and gin_value = head entry while gin_enable = 1, else 0.
  - Transfer occurs when gin_enable & gin_ready. On a transfer: pop the head and increment issued_count (wraps modulo 2^CNT_W).
  - While gin_enable = 1 and gin_ready = 0, gin_tag and gin_value must hold stable.
  - Back-to-back transfers run at 1 per cycle.
  - cfg_start → CFG. The FIFO is retained and issue is suspended; gin_enable drops in the same cycle as the CFG entry edge.
  - A cfg_start that coincides with a transfer completes that transfer first.
- FIFO:
  - Accepts packets in every state; pkt_ready = !full, from registered state only.
  - When full, a pop and an offered push in the same cycle are not combined: the push is refused that cycle.
  - When non-full, push and pop in the same cycle leave the occupancy unchanged.
  - Latency from the pkt accept edge to gin_enable = 1: next cycle, if in RUN and the FIFO was empty.
- Tag mismatch is not detected here. A tag matching no node stalls if gin_ready stays 0; that is the system's responsibility.
- Asynchronous reset mid-operation aborts CFG and discards the FIFO; set_id drops immediately.

Decomposition:
- Shared package gin_pkg holds:
  - ID_LEN and VALUE_LEN defaults;
  - the state encoding (IDLE=0, CFG=1, FLUSH=2, RUN=3);
  - the packet struct typedef {tag, value}.
- One sub-module, gin_sync_fifo: a parameterised width/depth synchronous FIFO with full/empty flags, async reset, and a registered head output.

Test Plan:
1. Config with NUM_NODES=3: reset, cfg_start, then cfg_id 2,1,0 on consecutive cycles → set_id high 3 consecutive cycles with id_out 2,1,0. FLUSH follows for 1 cycle, then cfg_done pulses once; a chain model of 3 controllers holds ids 0,1,2.
2. Basic issue: in RUN, push (tag=1, value=0xDEADBEEF) with gin_ready=1 → gin_enable=1 with gin_tag=1 and gin_value=0xDEADBEEF for exactly 1 cycle, then issued_count=1.
3. Backpressure: push 4 packets (values 10–13), gin_ready=0 for 5 cycles → outputs hold value 10 stable, pkt_ready=0 after the 4th push. Raising gin_ready then drains 10, 11, 12, 13 in 4 consecutive cycles.
4. Full plus simultaneous push/pop: with the FIFO full, gin_ready=1 and pkt_valid=1 → the push is refused that cycle and accepted the next; order is preserved and issued_count increments each cycle.
5. Reconfig mid-run: 2 packets queued, cfg_start asserted → gin_enable=0 during CFG/FLUSH. After cfg_done, both packets issue in order with no loss.
6. Reset mid-CFG: assert rst after 1 of 3 IDs → set_id=0, state IDLE, pkt_ready=1, issued_count=0; a new cfg_start restarts the node count from 0.
